// File: rtl/trb_in_demux.sv
// Deals whole fixed-length frames from one 8-bit stream to NUM_TURBO decoder inputs in
// strict round-robin order, regenerating sop/eop from a beat counter and flagging framing errors.
module trb_in_demux #(
   parameter int unsigned NUM_TURBO = 2,
   parameter int unsigned FRAME_LEN = 128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             st_data_in,
   input  logic                   st_valid_in,
   input  logic                   st_sop_in,
   input  logic                   st_eop_in,
   output logic                   st_ready_out,
   input  logic [NUM_TURBO-1:0]   st_ready_in,
   output logic [8*NUM_TURBO-1:0] st_data_out,
   output logic [NUM_TURBO-1:0]   st_valid_out,
   output logic [NUM_TURBO-1:0]   st_sop_out,
   output logic [NUM_TURBO-1:0]   st_eop_out,
   output logic [3:0]             sel_ch,
   output logic [15:0]            frame_cnt,
   output logic                   err_sync,
   output logic                   err_sop,
   output logic                   err_eop
);

   localparam int unsigned CntW = $clog2(FRAME_LEN);
   localparam int unsigned SelW = (NUM_TURBO > 1) ? $clog2(NUM_TURBO) : 1;
   localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_LEN - 1);
   localparam logic [3:0]      LastCh  = 4'(NUM_TURBO - 1);

   typedef enum logic {StSync, StStream} state_e;

   state_e                   state_q;
   logic [CntW-1:0]          cnt_q;
   logic [3:0]               sel_q;
   logic [15:0]              frame_q;
   logic [8*NUM_TURBO-1:0]   data_q;
   logic [NUM_TURBO-1:0]     valid_q, sop_q, eop_q;
   logic                     err_sync_q, err_sop_q, err_eop_q;

   logic accept, fwd, drop, bad_sop, bad_eop, last_beat;

   // Only the low bits address a channel; indices >= NUM_TURBO never occur.
   assign st_ready_out = rst_n & st_ready_in[sel_q[SelW-1:0]];
   assign accept       = st_valid_in & st_ready_out;

   always_comb begin
      fwd       = 1'b0;
      drop      = 1'b0;
      bad_sop   = 1'b0;
      bad_eop   = 1'b0;
      last_beat = 1'b0;
      if (accept) begin
         unique case (state_q)
            StSync: begin
               fwd  = st_sop_in;
               drop = ~st_sop_in;
            end
            StStream: begin
               fwd       = 1'b1;
               bad_sop   = st_sop_in;
               last_beat = (cnt_q == LastIdx);
               bad_eop   = st_eop_in ^ (cnt_q == LastIdx);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StSync;
         cnt_q      <= '0;
         sel_q      <= '0;
         frame_q    <= '0;
         data_q     <= '0;
         valid_q    <= '0;
         sop_q      <= '0;
         eop_q      <= '0;
         err_sync_q <= 1'b0;
         err_sop_q  <= 1'b0;
         err_eop_q  <= 1'b0;
      end else begin
         valid_q    <= '0;
         sop_q      <= '0;
         eop_q      <= '0;
         err_sync_q <= drop;
         err_sop_q  <= bad_sop;
         err_eop_q  <= bad_eop;
         if (fwd) begin
            for (int i = 0; i < NUM_TURBO; i++) begin
               if (sel_q == 4'(i)) begin
                  valid_q[i]        <= 1'b1;
                  sop_q[i]          <= (cnt_q == '0);
                  eop_q[i]          <= (cnt_q == LastIdx);
                  data_q[8*i +: 8]  <= st_data_in;
               end
            end
            if (last_beat) begin
               cnt_q   <= '0;
               sel_q   <= (sel_q == LastCh) ? 4'd0 : sel_q + 4'd1;
               frame_q <= frame_q + 16'd1;
               state_q <= StSync;
            end else begin
               cnt_q   <= cnt_q + CntW'(1);
               state_q <= StStream;
            end
         end
      end
   end

   assign st_data_out  = data_q;
   assign st_valid_out = valid_q;
   assign st_sop_out   = sop_q;
   assign st_eop_out   = eop_q;
   assign sel_ch       = sel_q;
   assign frame_cnt    = frame_q;
   assign err_sync     = err_sync_q;
   assign err_sop      = err_sop_q;
   assign err_eop      = err_eop_q;

endmodule

// File: tb/tb_trb_in_demux.sv
// Scoreboard bench for trb_in_demux: a 2-channel/128-beat instance checked beat by beat,
// plus a 16-channel/4-beat instance for the channel wrap.
module tb_trb_in_demux;

   localparam int NT  = 2;
   localparam int FL  = 128;
   localparam int BNT = 16;
   localparam int BFL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic              a_rst_n = 1'b0;
   logic [7:0]        a_data = '0;
   logic              a_valid = 1'b0, a_sop = 1'b0, a_eop = 1'b0;
   logic              a_rdy_out;
   logic [NT-1:0]     a_rdy_in = '1;
   logic [8*NT-1:0]   a_dout;
   logic [NT-1:0]     a_vout, a_sout, a_eout;
   logic [3:0]        a_sel;
   logic [15:0]       a_fcnt;
   logic              a_es, a_eso, a_eeo;

   logic              b_rst_n = 1'b0;
   logic [7:0]        b_data = '0;
   logic              b_valid = 1'b0, b_sop = 1'b0, b_eop = 1'b0;
   logic              b_rdy_out;
   logic [BNT-1:0]    b_rdy_in = '1;
   logic [8*BNT-1:0]  b_dout;
   logic [BNT-1:0]    b_vout, b_sout, b_eout;
   logic [3:0]        b_sel;
   logic [15:0]       b_fcnt;
   logic              b_es, b_eso, b_eeo;

   trb_in_demux #(.NUM_TURBO(NT), .FRAME_LEN(FL)) u_dut_a (
      .clk(clk), .rst_n(a_rst_n), .st_data_in(a_data), .st_valid_in(a_valid),
      .st_sop_in(a_sop), .st_eop_in(a_eop), .st_ready_out(a_rdy_out), .st_ready_in(a_rdy_in),
      .st_data_out(a_dout), .st_valid_out(a_vout), .st_sop_out(a_sout), .st_eop_out(a_eout),
      .sel_ch(a_sel), .frame_cnt(a_fcnt), .err_sync(a_es), .err_sop(a_eso), .err_eop(a_eeo)
   );

   trb_in_demux #(.NUM_TURBO(BNT), .FRAME_LEN(BFL)) u_dut_b (
      .clk(clk), .rst_n(b_rst_n), .st_data_in(b_data), .st_valid_in(b_valid),
      .st_sop_in(b_sop), .st_eop_in(b_eop), .st_ready_out(b_rdy_out), .st_ready_in(b_rdy_in),
      .st_data_out(b_dout), .st_valid_out(b_vout), .st_sop_out(b_sout), .st_eop_out(b_eout),
      .sel_ch(b_sel), .frame_cnt(b_fcnt), .err_sync(b_es), .err_sop(b_eso), .err_eop(b_eeo)
   );

   typedef struct {
      int         due;
      int         ch;
      logic [7:0] d;
      logic       sop;
      logic       eop;
      logic [2:0] err;
   } rec_t;

   rec_t sb[$];
   int total = 0;
   int bad = 0;
   int n_es = 0, n_eso = 0, n_eeo = 0;

   int m_sync = 1, m_cnt = 0, m_sel = 0, last_acc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Expected behaviour of one accepted beat, in spec terms.
   task automatic model_accept(input logic [7:0] d, input logic s, input logic e);
      rec_t r;
      r.due = cyc + 1; r.ch = -1; r.d = d; r.sop = 1'b0; r.eop = 1'b0; r.err = 3'b000;
      if (m_sync != 0) begin
         if (s) begin
            r.ch = m_sel; r.sop = 1'b1; m_cnt = 1; m_sync = 0;
         end else begin
            r.err = 3'b100;
         end
      end else begin
         r.ch  = m_sel;
         r.eop = (m_cnt == FL - 1);
         r.err = {1'b0, s, e != (m_cnt == FL - 1)};
         if (m_cnt == FL - 1) begin
            m_cnt = 0; m_sel = (m_sel + 1) % NT; m_sync = 1;
         end else begin
            m_cnt++;
         end
      end
      sb.push_back(r);
      last_acc = cyc + 1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
         rec_t r;
         logic [31:0] ev;
         r = sb.pop_front();
         ev = (r.ch >= 0) ? (32'd1 << r.ch) : 32'd0;
         chk("out_valid", 32'(a_vout), ev);
         chk("out_sop", 32'(a_sout), r.sop ? ev : 32'd0);
         chk("out_eop", 32'(a_eout), r.eop ? ev : 32'd0);
         chk("out_err", 32'({a_es, a_eso, a_eeo}), 32'(r.err));
         if (r.ch >= 0) chk("out_data", 32'(a_dout[8*r.ch +: 8]), 32'(r.d));
      end else if (a_vout != '0 || a_es || a_eso || a_eeo) begin
         total++;
         bad++;
         $display("FAIL unexpected_output: valid=%b err=%b expected nothing at cycle %0d",
                  a_vout, {a_es, a_eso, a_eeo}, cyc);
      end
      n_es  += int'(a_es);
      n_eso += int'(a_eso);
      n_eeo += int'(a_eeo);
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic send(input logic [7:0] d, input logic s, input logic e);
      int guard = 0;
      a_data = d; a_sop = s; a_eop = e; a_valid = 1'b1;
      while (1) begin
         logic exp_rdy;
         #1;
         exp_rdy = a_rst_n & a_rdy_in[m_sel];
         chk("ready_out", 32'(a_rdy_out), 32'(exp_rdy));
         if (exp_rdy) begin
            model_accept(d, s, e);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         guard++;
         if (guard > 64) begin
            total++; bad++;
            $display("FAIL send_timeout: ready stuck low, got 0 want 1 at cycle %0d", cyc);
            break;
         end
      end
      a_valid = 1'b0;
   endtask

   task automatic hold(input int n, input logic [7:0] d);
      a_data = d; a_sop = 1'b0; a_eop = 1'b0; a_valid = 1'b1;
      repeat (n) begin
         #1;
         chk("ready_stall", 32'(a_rdy_out), 32'd0);
         @(posedge clk); #1;
      end
      a_valid = 1'b0;
   endtask

   task automatic frame(input int seed, input int sop_at, input int eop_at,
                        input int stall_at, input int stop_at);
      for (int i = 0; i < FL; i++) begin
         if (i == stop_at) return;
         if (i == stall_at) begin
            a_rdy_in[m_sel] = 1'b0;
            hold(10, 8'(i + seed));
            a_rdy_in = '1;
         end
         send(8'(i + seed), (i == 0) || (i == sop_at), i == eop_at);
      end
   endtask

   task automatic check_idle(input string nm);
      chk({nm, "_valid"}, 32'(a_vout), 32'd0);
      chk({nm, "_sopeop"}, 32'({a_sout, a_eout}), 32'd0);
      chk({nm, "_data"}, 32'(a_dout), 32'd0);
      chk({nm, "_err"}, 32'({a_es, a_eso, a_eeo}), 32'd0);
      chk({nm, "_sel"}, 32'(a_sel), 32'd0);
      chk({nm, "_fcnt"}, 32'(a_fcnt), 32'd0);
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic realign();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int f0, b_es0, b_eso0, b_eeo0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 32'(a_rdy_out), 32'd0);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      check_idle("reset");

      // Four clean back-to-back frames.
      frame(0, -1, FL - 1, -1, -1);
      f0 = last_acc - (FL - 1);
      for (int k = 1; k < 4; k++) frame(k * 16, -1, FL - 1, -1, -1);
      chk("b2b_span", 32'(last_acc - f0), 32'd511);
      settle();
      chk("t1_fcnt", 32'(a_fcnt), 32'd4);
      chk("t1_sel", 32'(a_sel), 32'd0);
      chk("t1_errs", 32'(n_es + n_eso + n_eeo), 32'd0);
      realign();

      // Ch0 frame, then ch1 frame with ready[1] low for 10 cycles at beat 10.
      frame(7, -1, FL - 1, -1, -1);
      frame(0, -1, FL - 1, 10, -1);
      settle();
      chk("t2_fcnt", 32'(a_fcnt), 32'd6);
      chk("t2_sel", 32'(a_sel), 32'd0);
      realign();

      // Reset, three stray beats, then a clean frame.
      a_rst_n = 1'b0;
      realign();
      a_rst_n = 1'b1;
      m_sync = 1; m_cnt = 0; m_sel = 0;
      check_idle("rst2");
      b_es0 = n_es;
      send(8'hA1, 1'b0, 1'b0);
      send(8'hA2, 1'b0, 1'b1);
      send(8'hA3, 1'b0, 1'b0);
      frame(3, -1, FL - 1, -1, -1);
      settle();
      chk("t3_sync_pulses", 32'(n_es - b_es0), 32'd3);
      chk("t3_fcnt", 32'(a_fcnt), 32'd1);
      chk("t3_sel", 32'(a_sel), 32'd1);
      realign();

      // Bad framing on ch1: sop at 50, eop at 100, no eop at 127.
      b_eso0 = n_eso; b_eeo0 = n_eeo;
      frame(9, 50, 100, -1, -1);
      settle();
      chk("t4_sop_pulses", 32'(n_eso - b_eso0), 32'd1);
      chk("t4_eop_pulses", 32'(n_eeo - b_eeo0), 32'd2);
      chk("t4_fcnt", 32'(a_fcnt), 32'd2);
      chk("t4_sel", 32'(a_sel), 32'd0);
      realign();

      // Reset in the middle of a ch1 frame, then a clean frame to ch0.
      frame(5, -1, FL - 1, -1, -1);
      frame(11, -1, FL - 1, -1, 60);
      a_rst_n = 1'b0;
      a_data = 8'd71; a_sop = 1'b0; a_eop = 1'b0; a_valid = 1'b1;
      #1;
      chk("rst_mid_ready", 32'(a_rdy_out), 32'd0);
      @(posedge clk); #1;
      a_valid = 1'b0;
      a_rst_n = 1'b1;
      m_sync = 1; m_cnt = 0; m_sel = 0;
      check_idle("rst_mid");
      frame(13, -1, FL - 1, -1, -1);
      settle();
      chk("t5_fcnt", 32'(a_fcnt), 32'd1);
      chk("t5_sel", 32'(a_sel), 32'd1);
      realign();

      // 16 channels: 17 short frames, the last must wrap to ch0.
      b_es0 = 0;
      for (int f = 0; f < 17; f++) begin
         for (int i = 0; i < BFL; i++) begin
            b_valid = 1'b1; b_sop = (i == 0); b_eop = (i == BFL - 1); b_data = 8'(f * 4 + i);
            @(posedge clk); #1;
            if (i == 0) begin
               chk("b_sop_ch", 32'(b_sout), 32'd1 << (f % 16));
               chk("b_data", 32'(b_dout[8*(f%16) +: 8]), 32'(f * 4));
            end
            if (i == BFL - 1) begin
               chk("b_eop_ch", 32'(b_eout), 32'd1 << (f % 16));
               chk("b_sel", 32'(b_sel), 32'((f + 1) % 16));
            end
            b_es0 += int'(b_es | b_eso | b_eeo);
         end
      end
      b_valid = 1'b0;
      chk("b_fcnt", 32'(b_fcnt), 32'd17);
      chk("b_errs", 32'(b_es0), 32'd0);
      chk("b_ready", 32'(b_rdy_out), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
